// File: rtl/pc_sequencer.sv
// Multicycle control FSM that fetches, decodes and retires one instruction at a time,
// handshaking with instruction memory, the ALU and data memory, and strobing the PC.
module pc_sequencer #(
    parameter int unsigned PC_W    = 6,
    parameter int unsigned INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic               zero_flag,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               pc_enable,
    output logic               pc_branch,
    output logic [PC_W-1:0]    pc_target,
    output logic [INSTR_W-1:0] ir,
    output logic               halted,
    output logic               illegal
);

    localparam logic [3:0] OpNop   = 4'h0;
    localparam logic [3:0] OpAlu   = 4'h1;
    localparam logic [3:0] OpLoad  = 4'h2;
    localparam logic [3:0] OpStore = 4'h3;
    localparam logic [3:0] OpJmp   = 4'h4;
    localparam logic [3:0] OpBz    = 4'h5;
    localparam logic [3:0] OpHalt  = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StAluStart,
        StAluWait,
        StMem,
        StUpdate,
        StHalted
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               take_q, take_d;
    logic               illegal_q, illegal_d;
    logic [3:0]         opcode;

    assign opcode = ir_q[INSTR_W-1 -: 4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            take_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            take_q    <= take_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        take_d    = take_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // zero_flag only matters here; later changes cannot alter the branch
                take_d = (opcode == OpJmp) || ((opcode == OpBz) && zero_flag);
                case (opcode)
                    OpNop, OpJmp, OpBz: state_d = StUpdate;
                    OpAlu:              state_d = StAluStart;
                    OpLoad, OpStore:    state_d = StMem;
                    OpHalt:             state_d = StHalted;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StUpdate;
                    end
                endcase
            end
            StAluStart: state_d = StAluWait;
            StAluWait: begin
                if (alu_done) state_d = StUpdate;
            end
            StMem: begin
                if (dmem_ack) state_d = StUpdate;
            end
            StUpdate: state_d = run ? StFetch : StIdle;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    // Moore outputs: decoded purely from registered state
    assign imem_req  = (state_q == StFetch);
    assign alu_start = (state_q == StAluStart);
    assign dmem_req  = (state_q == StMem);
    assign dmem_we   = (state_q == StMem) && (opcode == OpStore);
    assign pc_enable = (state_q == StUpdate);
    assign pc_branch = (state_q == StUpdate) && take_q;
    assign pc_target = ir_q[PC_W-1:0];
    assign ir        = ir_q;
    assign halted    = (state_q == StHalted);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: drives random programs with random handshake latencies
// and compares each retirement against an instruction-level reference model.
module tb_pc_sequencer;

    localparam int unsigned PC_W    = 6;
    localparam int unsigned INSTR_W = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               run = 1'b0;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               alu_done = 1'b0;
    logic               zero_flag = 1'b0;
    logic               dmem_ack = 1'b0;
    logic               imem_req, alu_start, dmem_req, dmem_we;
    logic               pc_enable, pc_branch, halted, illegal;
    logic [PC_W-1:0]    pc_target;
    logic [INSTR_W-1:0] ir;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .zero_flag  (zero_flag),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc_enable  (pc_enable),
        .pc_branch  (pc_branch),
        .pc_target  (pc_target),
        .ir         (ir),
        .halted     (halted),
        .illegal    (illegal)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [INSTR_W-1:0] prog [64];

    task automatic gen_prog(input int halt_w);
        int         r;
        logic [3:0] o;
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 11 + halt_w);
            if (r < 2)       o = 4'h0;
            else if (r < 4)  o = 4'h1;
            else if (r < 6)  o = 4'h2;
            else if (r < 8)  o = 4'h3;
            else if (r < 9)  o = 4'h4;
            else if (r < 11) o = 4'h5;
            else if (r < 12) o = 4'($urandom_range(6, 14));
            else             o = 4'hF;
            prog[i] = {o, 8'($urandom)};
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, {imem_req, dmem_req, alu_start}, 0);
        check({tag, "_pc"}, {pc_enable, pc_branch, pc_target}, 0);
        check({tag, "_ir"}, ir, 0);
        check({tag, "_flags"}, {halted, illegal, dmem_we}, 0);
    endtask

    // One program run from reset; ends on HALT, after 30 retirements, or (stop_in_mem) in a
    // data access with the request still outstanding, then resets asynchronously mid-cycle.
    task automatic episode(input int halt_w, input bit stop_in_mem);
        int               n, cyc, fstart, fcnt, mcnt, acnt, halt_cnt, exp_c;
        int               fd, md, al;
        bit               zf, prev_req, prev_dreq, prev_pce, prev_as;
        bit               dec_pend, alu_pend, exp_req_chk, exp_req, ill_m, done, first;
        logic             exp_b;
        logic [3:0]       op;
        logic [PC_W-1:0]  mpc;
        logic [INSTR_W-1:0] cur;
        n = 0; cyc = 0; fstart = 0; fcnt = 0; mcnt = 0; acnt = 0; halt_cnt = 0;
        fd = 0; md = 0; al = 1; zf = 0;
        prev_req = 0; prev_dreq = 0; prev_pce = 0; prev_as = 0;
        dec_pend = 0; alu_pend = 0; exp_req_chk = 0; exp_req = 0; ill_m = 0;
        done = 0; first = 1; op = 4'h0; mpc = '0; cur = '0;
        gen_prog(halt_w);
        run = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        while (!done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (halt_cnt > 0) halt_cnt++;
            run = (first || halt_cnt > 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
            if (first) begin
                check("fetch_after_reset", imem_req, 1);
                first = 0;
            end
            if (exp_req_chk) begin
                check("run_after_update", imem_req, exp_req);
                exp_req_chk = 0;
            end
            if (halt_cnt == 3) begin
                check("halted_set", halted, 1);
                check("halt_illegal", illegal, ill_m);
            end
            if (halt_cnt >= 3) check("halt_quiet", {imem_req, dmem_req, alu_start, pc_enable}, 0);
            if (halt_cnt >= 23) done = 1;

            imem_ack   = 1'b0;
            imem_rdata = INSTR_W'($urandom);
            zero_flag  = 1'($urandom_range(0, 1));
            if (dec_pend) begin
                zero_flag = zf;
                dec_pend  = 0;
            end

            if (imem_req) begin
                if (!prev_req) begin
                    fstart = cyc;
                    fcnt   = 0;
                    fd     = $urandom_range(0, 3);
                    md     = $urandom_range(0, 3);
                    al     = $urandom_range(1, 6);
                    zf     = 1'($urandom_range(0, 1));
                end
                if (fcnt == fd) begin
                    imem_ack   = 1'b1;
                    cur        = prog[mpc];
                    imem_rdata = cur;
                    op         = cur[INSTR_W-1 -: 4];
                    dec_pend   = 1;
                    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF})) ill_m = 1;
                    if (op == 4'hF) halt_cnt = 1;
                end else begin
                    fcnt++;
                end
            end else begin
                imem_ack = ($urandom_range(0, 3) == 0);
            end

            if (alu_pend) begin
                acnt++;
                alu_done = (acnt == al);
                if (alu_done) alu_pend = 0;
            end else begin
                alu_done = ($urandom_range(0, 4) == 0);
            end
            if (alu_start) begin
                check("alu_start_pulse", prev_as, 0);
                check("alu_start_op", op, 4'h1);
                alu_pend = 1;
                acnt     = 0;
            end

            if (dmem_req) begin
                if (!prev_dreq) begin
                    mcnt = 0;
                    check("dmem_op", (op == 4'h2) || (op == 4'h3), 1);
                end
                check("dmem_we", dmem_we, (op == 4'h3));
                if (mcnt == md) dmem_ack = 1'b1;
                else begin
                    dmem_ack = 1'b0;
                    mcnt++;
                end
            end else begin
                dmem_ack = ($urandom_range(0, 3) == 0);
            end

            if (pc_enable) begin
                exp_b = (op == 4'h4) || ((op == 4'h5) && zf);
                exp_c = fd + 3;
                if (op == 4'h1) exp_c += al + 1;
                else if (op == 4'h2 || op == 4'h3) exp_c += md + 1;
                check("pc_enable_gap", prev_pce, 0);
                check("cycles", cyc - fstart + 1, exp_c);
                check("pc_branch", pc_branch, exp_b);
                check("pc_target", pc_target, cur[PC_W-1:0]);
                check("illegal", illegal, ill_m);
                check("halted_clear", halted, 0);
                mpc = exp_b ? cur[PC_W-1:0] : mpc + 1'b1;
                n++;
                exp_req_chk = 1;
                exp_req     = run;
            end

            prev_req  = imem_req;
            prev_dreq = dmem_req;
            prev_pce  = pc_enable;
            prev_as   = alu_start;
            if (halt_cnt == 0 && n >= 30 && (!stop_in_mem || dmem_req)) done = 1;
            if (cyc > 5000) begin
                check("episode_progress", n, 30);
                done = 1;
            end
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async_reset");
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        alu_done = 1'b0;
        @(negedge clk);
        check_reset_state("reset_held");
    endtask

    initial begin
        rst = 1'b0;
        #2;
        check_reset_state("por");
        #10;
        for (int e = 0; e < 8; e++) begin
            episode((e % 2 == 1) ? 2 : 0, (e == 2) || (e == 5));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
